cmd_dispatch_mc: RTL and testbench
==================================

CMD_DISPATCH_MC -- requirements
Module: cmd_dispatch_mc

Interface
REQ-001 Parameter NUM_CH, default 3: number of analog front-end channels, legal range 1..4.
REQ-002 Parameter TRIG_POS_W, default 9: width of the trigger-position register.
REQ-003 Parameter DEC_W, default 4: width of the decimator register.
REQ-004 Parameter SPI_TMO, default 1024: cycles allowed per SPI frame before timeout; legal range 2..65535.
REQ-005 clk  in  1  sole clock, all state on rising edge.
REQ-006 rst_n  in  1  reset, asynchronous, active-low.
REQ-007 cmd  in  24  command word: opcode cmd[19:16], ggg cmd[12:10], channel cmd[9:8], addr cmd[13:8], data cmd[7:0].
REQ-008 cmd_rdy  in  1 / clr_cmd_rdy  out  1  command handshake.
REQ-009 resp_data  out  8 / send_resp  out  1  single-cycle response strobe to UART.
REQ-010 ss  out  SlaveSelect / wrt_SPI  out  1 / SPI_data  out  16 / EEP_data  in  8 / SPI_done  in  1  SPI master interface.
REQ-011 start_dump  out  1 / dump_channel  out  2 / dump_data  in  8 / send_dump  in  1 / dump_finished  in  1 / set_capture_done  in  1  capture interface.
REQ-012 trig_cfg  out  6 / decimator  out  DEC_W / trig_pos  out  TRIG_POS_W  configuration registers.
REQ-013 cal_offset  out  8 signed / cal_gain  out  8  calibration of the dumped channel, valid from start_dump onward.

Function
REQ-014 States: IDLE, SPI_WR, RD_ADDR, RD_DATA, CAL_OFF_ADDR, CAL_OFF_DATA, CAL_GAIN_ADDR, CAL_GAIN_DATA, DUMP.
REQ-015 IDLE with cmd_rdy: clr_cmd_rdy=1 for exactly one cycle, opcode decoded that same cycle.
REQ-016 SET_TRIGPOS/SET_DEC/SET_TRIG_CFG: load cmd[TRIG_POS_W-1:0] / cmd[DEC_W-1:0] / cmd[13:8], send ACK (0xA5) the same cycle, stay IDLE.
REQ-017 READ_TRIG_CFG: resp_data={2'b00,trig_cfg}, send_resp=1, same cycle.
REQ-018 CONFIG_GAIN: store ggg into per-channel register, ss=channel select, SPI_data from gain table indexed by ggg, then SPI_WR.
REQ-019 SET_TRIGGER: SPI_data={8'h13,cmd[7:0]} on trigger select; WRITE_EEPROM: SPI_data={2'b01,cmd[13:0]} on EEPROM; both then SPI_WR.
REQ-020 SPI_WR: SPI_done -> ACK, IDLE.
REQ-021 READ_EEPROM: address frame {2'b00,cmd[13:8],8'h00} (RD_ADDR), then data frame (RD_DATA); SPI_done in RD_DATA -> resp_data=EEP_data, IDLE.
REQ-022 DUMP: latch dump_channel=cmd[9:8]; fetch offset at EEPROM addr {ch,ggg[ch],1'b0} then gain at {ch,ggg[ch],1'b1}, two frames each; then start_dump=1 for one cycle, enter DUMP.
REQ-023 Each new frame asserts wrt_SPI for exactly one cycle, issued in the cycle SPI_done of the previous frame is seen or on dispatch.
REQ-024 DUMP: send_dump -> resp_data=dump_data, send_resp=1 same cycle; dump_finished -> IDLE; send_dump wins if both are asserted.
REQ-025 Channel field >= NUM_CH on CONFIG_GAIN or DUMP: NACK (0xEE), no SPI frame, no register change.
REQ-026 Unknown opcode: NACK, stay IDLE.
REQ-027 Timeout: a 16-bit counter clears on every wrt_SPI; reaching SPI_TMO in any SPI wait state -> NACK, IDLE, no start_dump, no calibration update.
REQ-028 trig_cfg[5] is cleared on any cycle set_capture_done=1, overriding a simultaneous SET_TRIG_CFG write of bit 5.
REQ-029 cmd_rdy outside IDLE is ignored until the return to IDLE.

Reset
REQ-030 rst_n low forces IDLE; all registers, ggg table, cal_offset, cal_gain, dump_channel, and timeout counter go to 0.
REQ-031 While rst_n is low all strobes are 0 and ss=SS_NONE; reset mid-transaction aborts with no response.

Structure
REQ-032 Opcodes, ACK/NACK, the 8-entry gain table, and the state enum reside in the shared package beside SlaveSelect.
REQ-033 One sub-module, spi_tmo_cnt: counter with clear, enable, and terminal flag.

Verification
REQ-034 SET_DEC cmd=0x050007 -> one-cycle ACK 0xA5, decimator=7.
REQ-035 CONFIG_GAIN ch1 ggg=3 -> ss=SS_CH2, SPI_data=0x1314, ACK after SPI_done.
REQ-036 DUMP ch0 with EEPROM returning 0xF0 then 0x80 -> 4 frames, start_dump pulse, cal_offset=-16, cal_gain=0x80.
REQ-037 NUM_CH=2, DUMP ch2 -> NACK 0xEE, no wrt_SPI.
REQ-038 WRITE_EEPROM with SPI_done withheld -> NACK exactly SPI_TMO cycles after wrt_SPI, state IDLE.
REQ-039 set_capture_done coincident with SET_TRIG_CFG 0x3F -> trig_cfg=0x1F.

Source files
------------

// File: rtl/cmd_dispatch_mc_pkg.sv
// Shared types for the command dispatcher:
// slave selects, FSM states, opcodes, ACK/NACK, gain table.
package cmd_dispatch_mc_pkg;

  typedef enum logic [2:0] {
    SS_NONE = 3'd0,
    SS_CH1  = 3'd1,
    SS_CH2  = 3'd2,
    SS_CH3  = 3'd3,
    SS_CH4  = 3'd4,
    SS_TRIG = 3'd5,
    SS_EEP  = 3'd6
  } SlaveSelect;

  typedef enum logic [3:0] {
    IDLE,
    SPI_WR,
    RD_ADDR,
    RD_DATA,
    CAL_OFF_ADDR,
    CAL_OFF_DATA,
    CAL_GAIN_ADDR,
    CAL_GAIN_DATA,
    DUMP
  } state_t;

  localparam logic [3:0] OP_DUMP     = 4'h1;
  localparam logic [3:0] OP_CFG_GAIN = 4'h2;
  localparam logic [3:0] OP_SET_TRIG = 4'h3;
  localparam logic [3:0] OP_SET_TPOS = 4'h4;
  localparam logic [3:0] OP_SET_DEC  = 4'h5;
  localparam logic [3:0] OP_SET_TCFG = 4'h6;
  localparam logic [3:0] OP_RD_TCFG  = 4'h7;
  localparam logic [3:0] OP_WR_EEP   = 4'h8;
  localparam logic [3:0] OP_RD_EEP   = 4'h9;

  localparam logic [7:0] ACK  = 8'hA5;
  localparam logic [7:0] NACK = 8'hEE;

  // Front-end gain DAC frame for a ggg setting.
  function automatic logic [15:0] gain_frame(
    input logic [2:0] g
  );
    logic [7:0] v;
    unique case (g)
      3'd0: v = 8'h02;
      3'd1: v = 8'h05;
      3'd2: v = 8'h09;
      3'd3: v = 8'h14;
      3'd4: v = 8'h28;
      3'd5: v = 8'h46;
      3'd6: v = 8'h6B;
      3'd7: v = 8'hDD;
    endcase
    return {8'h13, v};
  endfunction

  // Channel n is wired to slave select SS_CH(n+1).
  function automatic SlaveSelect ch_ss(
    input logic [1:0] ch
  );
    return SlaveSelect'({1'b0, ch} + 3'd1);
  endfunction

endpackage

// File: rtl/cmd_dispatch_mc_spi_tmo_cnt.sv
// SPI frame timeout counter.
// clr restarts, en counts, tmo flags TMO cycles since clr.
module spi_tmo_cnt #(
  parameter int TMO = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tmo
);

  logic [15:0] cnt;

  // cnt reads k-1 in the k-th cycle after clr,
  // so tmo rises exactly TMO cycles after it.
  assign tmo = (cnt == 16'(TMO - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en && !tmo)
      cnt <= cnt + 16'd1;
  end

endmodule

// File: rtl/cmd_dispatch_mc.sv
// Command dispatcher: decodes UART commands, drives SPI
// frames, config regs, calibration fetch and dump control.
module cmd_dispatch_mc
  import cmd_dispatch_mc_pkg::*;
#(
  parameter int NUM_CH     = 3,
  parameter int TRIG_POS_W = 9,
  parameter int DEC_W      = 4,
  parameter int SPI_TMO    = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [23:0]            cmd,
  input  logic                   cmd_rdy,
  output logic                   clr_cmd_rdy,
  output logic [7:0]             resp_data,
  output logic                   send_resp,
  output SlaveSelect             ss,
  output logic                   wrt_SPI,
  output logic [15:0]            SPI_data,
  input  logic [7:0]             EEP_data,
  input  logic                   SPI_done,
  output logic                   start_dump,
  output logic [1:0]             dump_channel,
  input  logic [7:0]             dump_data,
  input  logic                   send_dump,
  input  logic                   dump_finished,
  input  logic                   set_capture_done,
  output logic [5:0]             trig_cfg,
  output logic [DEC_W-1:0]       decimator,
  output logic [TRIG_POS_W-1:0]  trig_pos,
  output logic signed [7:0]      cal_offset,
  output logic [7:0]             cal_gain
);

  state_t     st, nxt;
  SlaveSelect ss_q;
  logic [15:0] spi_q;
  logic [2:0]  ggg_q [4];
  logic [7:0]  off_q;
  logic        start_q;
  logic        tmo, wait_st;
  logic        ld_pos, ld_dec, ld_cfg;
  logic        ld_ggg, ld_dch, ld_off, ld_cal;

  logic [3:0] op;
  logic [1:0] ch;
  logic [2:0] g;
  logic       ch_ok;
  logic       unused_bits;

  assign op    = cmd[19:16];
  assign ch    = cmd[9:8];
  assign g     = cmd[12:10];
  assign ch_ok = {30'd0, ch} < NUM_CH;
  assign unused_bits = ^{cmd[23:20], cmd[15:14]};

  assign start_dump = start_q;

  assign wait_st = st inside {SPI_WR, RD_ADDR, RD_DATA,
                              CAL_OFF_ADDR, CAL_OFF_DATA,
                              CAL_GAIN_ADDR, CAL_GAIN_DATA};

  spi_tmo_cnt #(
    .TMO (SPI_TMO)
  ) u_tmo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (wrt_SPI),
    .en    (wait_st),
    .tmo   (tmo)
  );

  always_comb begin
    nxt         = st;
    clr_cmd_rdy = 1'b0;
    send_resp   = 1'b0;
    resp_data   = 8'h00;
    wrt_SPI     = 1'b0;
    SPI_data    = spi_q;
    ss          = (st == IDLE) ? SS_NONE : ss_q;
    ld_pos      = 1'b0;
    ld_dec      = 1'b0;
    ld_cfg      = 1'b0;
    ld_ggg      = 1'b0;
    ld_dch      = 1'b0;
    ld_off      = 1'b0;
    ld_cal      = 1'b0;
    // A frame that completes on the timeout cycle still counts.
    if (rst_n && wait_st && !SPI_done && tmo) begin
      resp_data = NACK;
      send_resp = 1'b1;
      nxt       = IDLE;
    end else if (rst_n) begin
      unique case (st)
        IDLE: if (cmd_rdy) begin
          clr_cmd_rdy = 1'b1;
          send_resp   = 1'b1;
          resp_data   = ACK;
          unique case (1'b1)
            (op == OP_SET_TPOS): ld_pos = 1'b1;
            (op == OP_SET_DEC):  ld_dec = 1'b1;
            (op == OP_SET_TCFG): ld_cfg = 1'b1;
            (op == OP_RD_TCFG):
              resp_data = {2'b00, trig_cfg};
            (op == OP_CFG_GAIN && ch_ok): begin
              send_resp = 1'b0;
              ld_ggg    = 1'b1;
              wrt_SPI   = 1'b1;
              ss        = ch_ss(ch);
              SPI_data  = gain_frame(g);
              nxt       = SPI_WR;
            end
            (op == OP_SET_TRIG): begin
              send_resp = 1'b0;
              wrt_SPI   = 1'b1;
              ss        = SS_TRIG;
              SPI_data  = {8'h13, cmd[7:0]};
              nxt       = SPI_WR;
            end
            (op == OP_WR_EEP): begin
              send_resp = 1'b0;
              wrt_SPI   = 1'b1;
              ss        = SS_EEP;
              SPI_data  = {2'b01, cmd[13:0]};
              nxt       = SPI_WR;
            end
            (op == OP_RD_EEP): begin
              send_resp = 1'b0;
              wrt_SPI   = 1'b1;
              ss        = SS_EEP;
              SPI_data  = {2'b00, cmd[13:8], 8'h00};
              nxt       = RD_ADDR;
            end
            (op == OP_DUMP && ch_ok): begin
              send_resp = 1'b0;
              ld_dch    = 1'b1;
              wrt_SPI   = 1'b1;
              ss        = SS_EEP;
              SPI_data  = {2'b00, ch, ggg_q[ch],
                           1'b0, 8'h00};
              nxt       = CAL_OFF_ADDR;
            end
            default: resp_data = NACK;
          endcase
        end
        SPI_WR: if (SPI_done) begin
          resp_data = ACK;
          send_resp = 1'b1;
          nxt       = IDLE;
        end
        RD_ADDR: if (SPI_done) begin
          wrt_SPI  = 1'b1;
          ss       = SS_EEP;
          SPI_data = 16'h0000;
          nxt      = RD_DATA;
        end
        RD_DATA: if (SPI_done) begin
          resp_data = EEP_data;
          send_resp = 1'b1;
          nxt       = IDLE;
        end
        CAL_OFF_ADDR: if (SPI_done) begin
          wrt_SPI  = 1'b1;
          ss       = SS_EEP;
          SPI_data = 16'h0000;
          nxt      = CAL_OFF_DATA;
        end
        CAL_OFF_DATA: if (SPI_done) begin
          ld_off   = 1'b1;
          wrt_SPI  = 1'b1;
          ss       = SS_EEP;
          SPI_data = {2'b00, dump_channel,
                      ggg_q[dump_channel], 1'b1, 8'h00};
          nxt      = CAL_GAIN_ADDR;
        end
        CAL_GAIN_ADDR: if (SPI_done) begin
          wrt_SPI  = 1'b1;
          ss       = SS_EEP;
          SPI_data = 16'h0000;
          nxt      = CAL_GAIN_DATA;
        end
        // Offset is held aside so a timeout leaves cal intact.
        CAL_GAIN_DATA: if (SPI_done) begin
          ld_cal = 1'b1;
          nxt    = DUMP;
        end
        DUMP: begin
          if (send_dump) begin
            resp_data = dump_data;
            send_resp = 1'b1;
          end else if (dump_finished) begin
            nxt = IDLE;
          end
        end
        default: nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st           <= IDLE;
      ss_q         <= SS_NONE;
      spi_q        <= '0;
      trig_cfg     <= '0;
      decimator    <= '0;
      trig_pos     <= '0;
      dump_channel <= '0;
      off_q        <= '0;
      start_q      <= 1'b0;
      cal_offset   <= '0;
      cal_gain     <= '0;
      for (int i = 0; i < 4; i++)
        ggg_q[i] <= '0;
    end else begin
      st      <= nxt;
      start_q <= ld_cal;
      if (wrt_SPI) begin
        ss_q  <= ss;
        spi_q <= SPI_data;
      end
      if (ld_pos) trig_pos  <= cmd[TRIG_POS_W-1:0];
      if (ld_dec) decimator <= cmd[DEC_W-1:0];
      if (ld_cfg) trig_cfg  <= cmd[13:8];
      // Capture-done wins over a same-cycle write of bit 5.
      if (set_capture_done) trig_cfg[5] <= 1'b0;
      if (ld_ggg) ggg_q[ch] <= g;
      if (ld_dch) dump_channel <= ch;
      if (ld_off) off_q <= EEP_data;
      if (ld_cal) begin
        cal_offset <= $signed(off_q);
        cal_gain   <= EEP_data;
      end
    end
  end

endmodule

// File: tb/tb_cmd_dispatch_mc.sv
// Scoreboard bench for cmd_dispatch_mc: reference model
// queues expected responses, frames and calibration.
module tb_cmd_dispatch_mc;
  import cmd_dispatch_mc_pkg::*;

  localparam int NCH = 2;
  localparam int TMO = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] cmd = '0;
  logic        cmd_rdy = 1'b0;
  logic        clr_cmd_rdy;
  logic [7:0]  resp_data;
  logic        send_resp;
  SlaveSelect  ss;
  logic        wrt_SPI;
  logic [15:0] SPI_data;
  logic [7:0]  EEP_data = '0;
  logic        SPI_done = 1'b0;
  logic        start_dump;
  logic [1:0]  dump_channel;
  logic [7:0]  dump_data = '0;
  logic        send_dump = 1'b0;
  logic        dump_finished = 1'b0;
  logic        set_capture_done = 1'b0;
  logic [5:0]  trig_cfg;
  logic [3:0]  decimator;
  logic [8:0]  trig_pos;
  logic signed [7:0] cal_offset;
  logic [7:0]  cal_gain;

  cmd_dispatch_mc #(
    .NUM_CH(NCH), .TRIG_POS_W(9), .DEC_W(4), .SPI_TMO(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .resp_data(resp_data),
    .send_resp(send_resp), .ss(ss), .wrt_SPI(wrt_SPI),
    .SPI_data(SPI_data), .EEP_data(EEP_data),
    .SPI_done(SPI_done), .start_dump(start_dump),
    .dump_channel(dump_channel), .dump_data(dump_data),
    .send_dump(send_dump), .dump_finished(dump_finished),
    .set_capture_done(set_capture_done),
    .trig_cfg(trig_cfg), .decimator(decimator),
    .trig_pos(trig_pos), .cal_offset(cal_offset),
    .cal_gain(cal_gain)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  logic [7:0]  exp_resp [$];
  logic [18:0] exp_frm  [$];
  logic [15:0] exp_cal  [$];

  logic [7:0] em [64];
  logic [2:0] m_ggg [4];
  logic [5:0] m_cfg;
  logic [3:0] m_dec;
  logic [8:0] m_pos;
  logic [1:0] m_dch;
  bit dump_pending, withhold, tmo_chk;
  int wrt_cyc;

  logic [7:0] gt [8] = '{8'h02, 8'h05, 8'h09, 8'h14,
                         8'h28, 8'h46, 8'h6B, 8'hDD};
  SlaveSelect chs [4] = '{SS_CH1, SS_CH2, SS_CH3, SS_CH4};

  task automatic chk(input string n, input logic [63:0] a,
                     input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT emits.
  always @(negedge clk) if (rst_n) begin
    if (send_resp) begin
      if (exp_resp.size() == 0) begin
        checks++; errors++;
        $display("FAIL resp: got %0h expected none", resp_data);
      end else
        chk("resp", resp_data, exp_resp.pop_front());
      if (tmo_chk) begin
        chk("tmo_latency", 64'(cyc - wrt_cyc), 64'(TMO));
        tmo_chk = 0;
      end
    end
    if (wrt_SPI) begin
      wrt_cyc = cyc;
      if (exp_frm.size() == 0) begin
        checks++; errors++;
        $display("FAIL frame: got %0h expected none",
                 {ss, SPI_data});
      end else
        chk("frame", {ss, SPI_data}, exp_frm.pop_front());
    end
    if (start_dump) begin
      if (exp_cal.size() == 0) begin
        checks++; errors++;
        $display("FAIL start_dump: got 1 expected 0");
      end else
        chk("cal", {cal_offset, cal_gain}, exp_cal.pop_front());
    end
  end

  // SPI slave: completes each frame after 1..4 cycles;
  // read data is the byte at the previous frame's address.
  int busy = 0;
  logic [5:0] prev_a = '0;
  logic [7:0] nxt_eep = '0;
  always @(negedge clk) if (rst_n && wrt_SPI) begin
    busy    = $urandom_range(1, 4);
    nxt_eep = em[prev_a];
    prev_a  = SPI_data[13:8];
  end
  always @(posedge clk) begin
    #1;
    SPI_done = 1'b0;
    if (busy > 0) begin
      busy--;
      if (busy == 0 && !withhold) begin
        SPI_done = 1'b1;
        EEP_data = nxt_eep;
      end
    end
  end

  task automatic model(input logic [23:0] c, input bit cap);
    logic [3:0] op;
    logic [1:0] ch;
    logic [2:0] g;
    logic [5:0] a, oa, ga;
    logic [7:0] d;
    op = c[19:16]; ch = c[9:8]; g = c[12:10];
    a = c[13:8]; d = c[7:0];
    case (op)
      4'h1: if (int'(ch) >= NCH) exp_resp.push_back(8'hEE);
      else begin
        oa = {ch, m_ggg[ch], 1'b0};
        ga = {ch, m_ggg[ch], 1'b1};
        exp_frm.push_back({SS_EEP, 2'b00, oa, 8'h00});
        exp_frm.push_back({SS_EEP, 16'h0000});
        exp_frm.push_back({SS_EEP, 2'b00, ga, 8'h00});
        exp_frm.push_back({SS_EEP, 16'h0000});
        exp_cal.push_back({em[oa], em[ga]});
        m_dch = ch;
        dump_pending = 1;
      end
      4'h2: if (int'(ch) >= NCH) exp_resp.push_back(8'hEE);
      else begin
        m_ggg[ch] = g;
        exp_frm.push_back({chs[ch], 8'h13, gt[g]});
        exp_resp.push_back(8'hA5);
      end
      4'h3: begin
        exp_frm.push_back({SS_TRIG, 8'h13, d});
        exp_resp.push_back(8'hA5);
      end
      4'h4: begin m_pos = c[8:0]; exp_resp.push_back(8'hA5); end
      4'h5: begin m_dec = c[3:0]; exp_resp.push_back(8'hA5); end
      4'h6: begin m_cfg = a; exp_resp.push_back(8'hA5); end
      4'h7: exp_resp.push_back({2'b00, m_cfg});
      4'h8: begin
        exp_frm.push_back({SS_EEP, 2'b01, c[13:0]});
        if (withhold) exp_resp.push_back(8'hEE);
        else begin em[a] = d; exp_resp.push_back(8'hA5); end
      end
      4'h9: begin
        exp_frm.push_back({SS_EEP, 2'b00, a, 8'h00});
        exp_frm.push_back({SS_EEP, 16'h0000});
        exp_resp.push_back(em[a]);
      end
      default: exp_resp.push_back(8'hEE);
    endcase
    if (cap) m_cfg[5] = 1'b0;
  endtask

  task automatic wait_done();
    int k = 0;
    while ((exp_resp.size() != 0 || exp_frm.size() != 0 ||
            exp_cal.size() != 0) && k < 400) begin
      @(posedge clk);
      k++;
    end
    if (k >= 400) begin
      checks++; errors++;
      $display("FAIL wait: pending resp=%0d frm=%0d cal=%0d expected 0",
               exp_resp.size(), exp_frm.size(), exp_cal.size());
      exp_resp.delete(); exp_frm.delete(); exp_cal.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic issue(input logic [23:0] c, input bit cap);
    model(c, cap);
    @(posedge clk); #1;
    cmd = c; cmd_rdy = 1'b1; set_capture_done = cap;
    @(negedge clk);
    chk("clr_cmd_rdy", clr_cmd_rdy, 1);
    @(posedge clk); #1;
    cmd_rdy = 1'b0; set_capture_done = 1'b0;
  endtask

  task automatic dump_phase();
    int n = $urandom_range(0, 4);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      send_dump = 1'b1;
      dump_data = 8'($urandom);
      dump_finished = 1'($urandom_range(0, 1));
      exp_resp.push_back(dump_data);
    end
    @(posedge clk); #1;
    send_dump = 1'b0; dump_finished = 1'b1;
    @(posedge clk); #1;
    dump_finished = 1'b0;
    dump_pending = 0;
    wait_done();
    chk("dump_channel", dump_channel, m_dch);
  endtask

  task automatic do_cmd(input logic [23:0] c, input bit cap);
    issue(c, cap);
    wait_done();
    if (dump_pending) dump_phase();
    chk("decimator", decimator, m_dec);
    chk("trig_pos", trig_pos, m_pos);
    chk("trig_cfg", trig_cfg, m_cfg);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; cmd_rdy = 1'b1; cmd = 24'h020D00;
    @(negedge clk);
    chk("rst_strobes",
        {clr_cmd_rdy, send_resp, wrt_SPI, start_dump}, 0);
    chk("rst_ss", ss, SS_NONE);
    chk("rst_regs", {trig_cfg, decimator, trig_pos,
        cal_offset, cal_gain, dump_channel}, 0);
    exp_resp.delete(); exp_frm.delete(); exp_cal.delete();
    for (int i = 0; i < 4; i++) m_ggg[i] = '0;
    m_cfg = '0; m_dec = '0; m_pos = '0; m_dch = '0;
    dump_pending = 0; tmo_chk = 0; withhold = 0; busy = 0;
    @(posedge clk); #1;
    rst_n = 1'b1; cmd_rdy = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) em[i] = 8'($urandom);
    do_reset();
    // Decimator load.
    do_cmd(24'h050007, 0);
    // Gain on ch1 ggg=3.
    do_cmd(24'h020D00, 0);
    // Calibration fetch for ch0 (ggg 0).
    do_cmd(24'h0800F0, 0);
    do_cmd(24'h080180, 0);
    do_cmd(24'h010000, 0);
    chk("cal_offset", 64'(int'(cal_offset)), 64'(-16));
    chk("cal_gain", cal_gain, 8'h80);
    // Channels beyond NUM_CH.
    do_cmd(24'h010200, 0);
    do_cmd(24'h021F00, 0);
    // Timeout on a withheld EEPROM write.
    withhold = 1; tmo_chk = 1;
    do_cmd(24'h083355, 0);
    withhold = 0;
    do_cmd(24'h093300, 0);
    // Capture-done beats a write of bit 5.
    do_cmd(24'h063F00, 1);
    do_cmd(24'h070000, 0);
    do_cmd(24'h0F1234, 0);
    // Reset in the middle of an EEPROM read.
    withhold = 1;
    issue(24'h090500, 0);
    repeat (5) @(posedge clk);
    do_reset();
    do_cmd(24'h070000, 0);
    // Random command mix.
    for (int i = 0; i < 80; i++) begin
      int r = $urandom_range(0, 19);
      logic [3:0] op;
      logic [23:0] c;
      op = (r < 18) ? 4'(r % 9 + 1) : ((r == 18) ? 4'h0 : 4'hC);
      c = {4'($urandom), op, 16'($urandom)};
      do_cmd(c, $urandom_range(0, 7) == 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

endmodule
